// File: rtl/arcade_dl_ctrl.sv
// Download-stream controller: demultiplexes the hps_io ioctl byte stream into
// the ROM write bus, the game-variant "mod" byte and the DIP-switch bank, and
// stretches the core reset around ROM loads.
module arcade_dl_ctrl #(
  parameter int RESET_HOLD = 16,
  parameter int ROM_AW     = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ROM_AW-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic [7:0]        mod,
  output logic              mod_valid,
  output logic [63:0]       sw_flat,
  output logic [7:0]        checksum,
  output logic              rom_overflow,
  output logic              core_reset,
  output logic              dl_active
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ROM  = 3'd1,
    S_MOD  = 3'd2,
    S_DIP  = 3'd3,
    S_SKIP = 3'd4,
    S_HOLD = 3'd5
  } state_e;

  localparam logic [7:0] HOLD_INIT = 8'(RESET_HOLD - 1);

  state_e              state_q, state_d;
  logic [7:0]          hold_cnt_q, hold_cnt_d;
  logic                dl_q;
  logic [ROM_AW-1:0]   dn_addr_q, dn_addr_d;
  logic [7:0]          dn_data_q, dn_data_d;
  logic                dn_wr_q, dn_wr_d;
  logic [7:0]          mod_q, mod_d;
  logic                mod_valid_q, mod_valid_d;
  logic [63:0]         sw_flat_q, sw_flat_d;
  logic [7:0]          checksum_q, checksum_d;
  logic                rom_overflow_q, rom_overflow_d;
  logic                core_reset_q, core_reset_d;
  logic                dl_active_q, dl_active_d;

  logic                rise_s, fall_s, rom_in_range_s;

  // Destination selected by the index sampled on the download rise.
  function automatic state_e index_target(input logic [7:0] idx);
    state_e t;
    case (idx)
      8'd0:    t = S_ROM;
      8'd1:    t = S_MOD;
      8'd254:  t = S_DIP;
      default: t = S_SKIP;
    endcase
    return t;
  endfunction

  assign rise_s         = ioctl_download & ~dl_q;
  assign fall_s         = ~ioctl_download & dl_q;
  assign rom_in_range_s = (ioctl_addr[24:ROM_AW] == {(25-ROM_AW){1'b0}});

  // Next-state and hold-counter logic.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rise_s) state_d = index_target(ioctl_index);
        else        state_d = S_IDLE;
      end
      S_ROM: begin
        if (fall_s) begin
          state_d    = S_HOLD;
          hold_cnt_d = HOLD_INIT;
        end else begin
          state_d = S_ROM;
        end
      end
      S_MOD, S_DIP, S_SKIP: begin
        if (fall_s) state_d = S_IDLE;
        else        state_d = state_q;
      end
      S_HOLD: begin
        // A new download abandons the remaining hold time.
        if (rise_s)                  state_d = index_target(ioctl_index);
        else if (hold_cnt_q == 8'd0) state_d = S_IDLE;
        else                         hold_cnt_d = hold_cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write demultiplexing and registered output values.
  always_comb begin
    dn_addr_d      = dn_addr_q;
    dn_data_d      = dn_data_q;
    dn_wr_d        = 1'b0;
    mod_d          = mod_q;
    mod_valid_d    = mod_valid_q;
    sw_flat_d      = sw_flat_q;
    checksum_d     = checksum_q;
    rom_overflow_d = rom_overflow_q;

    // Writes are handled in the state current this cycle, so a write on the
    // fall cycle still lands.
    if (ioctl_wr && (state_q == S_ROM)) begin
      if (rom_in_range_s) begin
        dn_wr_d    = 1'b1;
        dn_addr_d  = ioctl_addr[ROM_AW-1:0];
        dn_data_d  = ioctl_dout;
        checksum_d = checksum_q + ioctl_dout;
      end else begin
        rom_overflow_d = 1'b1;
      end
    end else if (ioctl_wr && (state_q == S_MOD)) begin
      if (ioctl_addr == 25'd0) begin
        mod_d       = ioctl_dout;
        mod_valid_d = 1'b1;
      end else begin
        mod_d = mod_q;
      end
    end else if (ioctl_wr && (state_q == S_DIP)) begin
      if (ioctl_addr[24:3] == 22'd0) sw_flat_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
      else                           sw_flat_d = sw_flat_q;
    end else begin
      dn_wr_d = 1'b0;
    end

    // Entering ROM starts a fresh checksum and overflow record. A write cannot
    // coincide with entry because entry only happens from IDLE or HOLD.
    if ((state_d == S_ROM) && (state_q != S_ROM)) begin
      checksum_d     = 8'd0;
      rom_overflow_d = 1'b0;
    end else begin
      checksum_d = checksum_d;
    end

    // The MOD, DIP and SKIP states are only reachable from IDLE (reset already
    // low) or from HOLD (hold abandoned), so core_reset follows ROM/HOLD occupancy.
    core_reset_d = (state_d == S_ROM) || (state_d == S_HOLD);
    dl_active_d  = (state_d != S_IDLE) && (state_d != S_HOLD);
  end

  // State, edge-detect and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_HOLD;
      hold_cnt_q     <= HOLD_INIT;
      dl_q           <= 1'b0;
      dn_addr_q      <= {ROM_AW{1'b0}};
      dn_data_q      <= 8'd0;
      dn_wr_q        <= 1'b0;
      mod_q          <= 8'd0;
      mod_valid_q    <= 1'b0;
      sw_flat_q      <= 64'hFFFF_FFFF_FFFF_FFFF;
      checksum_q     <= 8'd0;
      rom_overflow_q <= 1'b0;
      core_reset_q   <= 1'b1;
      dl_active_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      dl_q           <= ioctl_download;
      dn_addr_q      <= dn_addr_d;
      dn_data_q      <= dn_data_d;
      dn_wr_q        <= dn_wr_d;
      mod_q          <= mod_d;
      mod_valid_q    <= mod_valid_d;
      sw_flat_q      <= sw_flat_d;
      checksum_q     <= checksum_d;
      rom_overflow_q <= rom_overflow_d;
      core_reset_q   <= core_reset_d;
      dl_active_q    <= dl_active_d;
    end
  end

  assign dn_addr      = dn_addr_q;
  assign dn_data      = dn_data_q;
  assign dn_wr        = dn_wr_q;
  assign mod          = mod_q;
  assign mod_valid    = mod_valid_q;
  assign sw_flat      = sw_flat_q;
  assign checksum     = checksum_q;
  assign rom_overflow = rom_overflow_q;
  assign core_reset   = core_reset_q;
  assign dl_active    = dl_active_q;

endmodule

// File: tb/tb_arcade_dl_ctrl.sv
// Directed self-checking bench for arcade_dl_ctrl.
module tb_arcade_dl_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [7:0]  mod;
  logic        mod_valid;
  logic [63:0] sw_flat;
  logic [7:0]  checksum;
  logic        rom_overflow;
  logic        core_reset;
  logic        dl_active;

  int total = 0;
  int bad   = 0;

  arcade_dl_ctrl #(.RESET_HOLD(16), .ROM_AW(16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .mod(mod), .mod_valid(mod_valid), .sw_flat(sw_flat), .checksum(checksum),
    .rom_overflow(rom_overflow), .core_reset(core_reset), .dl_active(dl_active)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    tick();
  endtask

  task automatic end_dl;
    ioctl_download = 1'b0;
    tick();
  endtask

  // Counts cycles until core_reset drops, bounded at 100.
  task automatic count_reset(output int n);
    n = 0;
    while (core_reset && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
    #23;
    total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL rst_core_reset got=%b exp=1", core_reset); end
    total++; if (sw_flat !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL rst_sw_flat got=%h", sw_flat); end
    total++; if (mod !== 8'd0 || mod_valid !== 1'b0) begin bad++; $display("FAIL rst_mod got=%h/%b exp=00/0", mod, mod_valid); end
    total++; if (dn_wr !== 1'b0 || dl_active !== 1'b0 || checksum !== 8'd0 || rom_overflow !== 1'b0)
      begin bad++; $display("FAIL rst_misc dn_wr=%b dl_active=%b cks=%h ovf=%b", dn_wr, dl_active, checksum, rom_overflow); end
    reset_n = 1'b1;
    count_reset(n);
    total++; if (n !== 16) begin bad++; $display("FAIL rst_hold_len got=%0d exp=16", n); end
  endtask

  task automatic test_rom;
    logic [7:0] bytes [3];
    int n;
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'hFF;
    start_dl(8'd0);
    total++; if (dl_active !== 1'b1 || core_reset !== 1'b1) begin bad++; $display("FAIL rom_entry dl_active=%b core_reset=%b", dl_active, core_reset); end
    for (int i = 0; i < 3; i++) begin
      wr_byte(25'(i), bytes[i]);
      total++;
      if (dn_wr !== 1'b1 || dn_addr !== 16'(i) || dn_data !== bytes[i]) begin
        bad++; $display("FAIL rom_wr%0d got wr=%b a=%h d=%h exp wr=1 a=%h d=%h", i, dn_wr, dn_addr, dn_data, i, bytes[i]);
      end
      tick();
      total++;
      if (dn_wr !== 1'b0 || dn_addr !== 16'(i) || core_reset !== 1'b1) begin
        bad++; $display("FAIL rom_idle%0d got wr=%b a=%h rst=%b", i, dn_wr, dn_addr, core_reset);
      end
    end
    total++; if (checksum !== 8'h02) begin bad++; $display("FAIL rom_checksum got=%h exp=02", checksum); end
    end_dl();
    total++; if (core_reset !== 1'b1 || dl_active !== 1'b0) begin bad++; $display("FAIL rom_fall rst=%b act=%b", core_reset, dl_active); end
    count_reset(n);
    total++; if (n !== 16) begin bad++; $display("FAIL rom_hold_len got=%0d exp=16", n); end
  endtask

  task automatic test_overflow;
    int n;
    start_dl(8'd0);
    wr_byte(25'd5, 8'h10);
    total++; if (checksum !== 8'h10 || dn_wr !== 1'b1) begin bad++; $display("FAIL ovf_pre cks=%h wr=%b", checksum, dn_wr); end
    tick();
    wr_byte(25'h10000, 8'h77);
    total++; if (dn_wr !== 1'b0 || rom_overflow !== 1'b1 || checksum !== 8'h10 || dn_addr !== 16'd5)
      begin bad++; $display("FAIL ovf_drop wr=%b ovf=%b cks=%h a=%h exp 0/1/10/0005", dn_wr, rom_overflow, checksum, dn_addr); end
    end_dl();
    count_reset(n);
    total++; if (rom_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", rom_overflow); end
    start_dl(8'd0);
    total++; if (rom_overflow !== 1'b0 || checksum !== 8'h00) begin bad++; $display("FAIL ovf_clear ovf=%b cks=%h exp 0/00", rom_overflow, checksum); end
    end_dl();
    count_reset(n);
    total++; if (n !== 16) begin bad++; $display("FAIL ovf_hold_len got=%0d exp=16", n); end
  endtask

  task automatic test_mod;
    start_dl(8'd1);
    total++; if (dl_active !== 1'b1 || core_reset !== 1'b0) begin bad++; $display("FAIL mod_entry act=%b rst=%b", dl_active, core_reset); end
    wr_byte(25'd0, 8'h0B);
    total++; if (mod !== 8'h0B || mod_valid !== 1'b1) begin bad++; $display("FAIL mod_cap got=%h/%b exp=0b/1", mod, mod_valid); end
    wr_byte(25'd1, 8'h05);
    total++; if (mod !== 8'h0B || dn_wr !== 1'b0) begin bad++; $display("FAIL mod_addr1 got=%h wr=%b exp=0b/0", mod, dn_wr); end
    end_dl();
    total++; if (dl_active !== 1'b0 || core_reset !== 1'b0) begin bad++; $display("FAIL mod_end act=%b rst=%b", dl_active, core_reset); end
  endtask

  task automatic test_dip;
    start_dl(8'd254);
    wr_byte(25'd2, 8'hAA);
    wr_byte(25'd9, 8'h55);
    end_dl();
    total++; if (sw_flat !== 64'hFFFF_FFFF_FFAA_FFFF) begin bad++; $display("FAIL dip_bank got=%h exp=ffffffffffaaffff", sw_flat); end
    start_dl(8'd7);
    wr_byte(25'd0, 8'h33);
    total++; if (dn_wr !== 1'b0) begin bad++; $display("FAIL skip_dnwr got=%b exp=0", dn_wr); end
    wr_byte(25'd2, 8'h33);
    end_dl();
    total++; if (sw_flat !== 64'hFFFF_FFFF_FFAA_FFFF || mod !== 8'h0B || mod_valid !== 1'b1 || checksum !== 8'h00 || core_reset !== 1'b0)
      begin bad++; $display("FAIL skip_nochange sw=%h mod=%h v=%b cks=%h rst=%b", sw_flat, mod, mod_valid, checksum, core_reset); end
  endtask

  task automatic test_hold_rise;
    start_dl(8'd0);
    end_dl();
    for (int i = 0; i < 4; i++) tick();
    total++; if (core_reset !== 1'b1 || dl_active !== 1'b0) begin bad++; $display("FAIL hold_mid rst=%b act=%b", core_reset, dl_active); end
    start_dl(8'd1);
    total++; if (core_reset !== 1'b0 || dl_active !== 1'b1) begin bad++; $display("FAIL hold_abandon rst=%b act=%b exp 0/1", core_reset, dl_active); end
    wr_byte(25'd0, 8'h21);
    total++; if (mod !== 8'h21) begin bad++; $display("FAIL hold_mod got=%h exp=21", mod); end
    end_dl();
  endtask

  task automatic test_reset_mid_rom;
    int n;
    bit  low_seen;
    start_dl(8'd0);
    wr_byte(25'd0, 8'h40);
    total++; if (checksum !== 8'h40) begin bad++; $display("FAIL mid_pre cks=%h exp=40", checksum); end
    reset_n = 1'b0;
    #2;
    total++; if (checksum !== 8'h00 || dl_active !== 1'b0 || core_reset !== 1'b1 || mod !== 8'h00)
      begin bad++; $display("FAIL mid_rst cks=%h act=%b rst=%b mod=%h", checksum, dl_active, core_reset, mod); end
    reset_n = 1'b1;
    low_seen = 1'b0;
    tick();
    if (core_reset !== 1'b1) low_seen = 1'b1;
    total++; if (dl_active !== 1'b1) begin bad++; $display("FAIL mid_fresh_rom act=%b exp=1", dl_active); end
    wr_byte(25'd3, 8'h09);
    if (core_reset !== 1'b1) low_seen = 1'b1;
    total++; if (dn_wr !== 1'b1 || dn_addr !== 16'd3 || checksum !== 8'h09) begin bad++; $display("FAIL mid_wr wr=%b a=%h cks=%h", dn_wr, dn_addr, checksum); end
    end_dl();
    if (core_reset !== 1'b1) low_seen = 1'b1;
    total++; if (low_seen) begin bad++; $display("FAIL mid_core_reset got=dropped exp=held"); end
    count_reset(n);
    total++; if (n !== 16) begin bad++; $display("FAIL mid_hold_len got=%0d exp=16", n); end
  endtask

  initial begin
    test_reset();
    test_rom();
    test_overflow();
    test_mod();
    test_dip();
    test_hold_rise();
    test_reset_mid_rom();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
